// File: rtl/adc_serial_capture.sv
// adc_serial_capture
// Serial-ADC frame reader driven by the ADC's free-running serial clock.
// Generates cs_n framing, shifts in one conversion per frame (lead bits,
// MSB-first data bits, trailing bits), drops start-up frames, optionally
// box-car averages 2^AVG_LOG2 samples and presents each result on a
// valid/ready handshake with a one-cycle overrun pulse when a result is lost.

module adc_serial_capture #(
    parameter int DATA_W       = 12,
    parameter int LEAD_BITS    = 1,
    parameter int TRAIL_BITS   = 1,
    parameter int QUIET_CYCLES = 4,
    parameter int DISCARD      = 3,
    parameter int AVG_LOG2     = 0
) (
    input  logic              sck,
    input  logic              rst,
    input  logic              en_i,
    input  logic              miso,
    output logic              cs_n,
    output logic [DATA_W-1:0] data_o,
    output logic              error_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o,
    output logic              busy_o
);

    localparam int FRAME_BITS = LEAD_BITS + DATA_W + TRAIL_BITS;
    localparam int BIT_W      = $clog2(FRAME_BITS + 1);
    localparam int Q_W        = $clog2(QUIET_CYCLES + 1);
    localparam int ACC_W      = DATA_W + AVG_LOG2;
    localparam int WIN_W      = AVG_LOG2 + 1;

    // Bit positions inside a frame (bit_cnt values).
    localparam logic [BIT_W-1:0] LEAD_END = BIT_W'(LEAD_BITS);
    localparam logic [BIT_W-1:0] DATA_END = BIT_W'(LEAD_BITS + DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
    localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(QUIET_CYCLES - 1);
    localparam logic [3:0]       DISCARD_L = 4'(DISCARD);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_QUIET = 2'd2
    } state_t;

    state_t             state_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [Q_W-1:0]     q_cnt_r;
    logic [DATA_W-1:0]  sample_r;
    logic               frame_err_r;
    logic [3:0]         discard_cnt_r;
    logic [WIN_W-1:0]   win_cnt_r;
    logic [ACC_W-1:0]   acc_r;
    logic               win_err_r;

    logic [DATA_W-1:0]  sample_nxt_s;
    logic               frame_err_nxt_s;
    logic               frame_done_s;
    logic               keep_s;
    logic               win_close_s;
    logic [ACC_W-1:0]   acc_sum_s;
    logic               win_err_nxt_s;
    logic [DATA_W-1:0]  result_s;

    // Value of the sample and lead-error flag including the bit sampled on this edge,
    // so a frame can be completed on its last edge even with no trailing bits.
    always_comb begin
        sample_nxt_s    = sample_r;
        frame_err_nxt_s = frame_err_r;
        if (state_r == ST_FRAME) begin
            if (bit_cnt_r < LEAD_END) begin
                frame_err_nxt_s = frame_err_r | miso;
            end else if (bit_cnt_r < DATA_END) begin
                sample_nxt_s = {sample_r[DATA_W-2:0], miso};
            end else begin
                sample_nxt_s = sample_r;
            end
        end else begin
            sample_nxt_s    = sample_r;
            frame_err_nxt_s = frame_err_r;
        end
    end

    // Frame completion decode: discard versus accumulate, and window closing.
    always_comb begin
        frame_done_s  = (state_r == ST_FRAME) && (bit_cnt_r == BIT_LAST);
        keep_s        = 1'b0;
        if (frame_done_s && (discard_cnt_r >= DISCARD_L)) begin
            keep_s = 1'b1;
        end else begin
            keep_s = 1'b0;
        end
        acc_sum_s     = acc_r + ACC_W'(sample_nxt_s);
        win_err_nxt_s = win_err_r | frame_err_nxt_s;
        win_close_s   = keep_s && (win_cnt_r == WIN_LAST);
        // Truncating divide by the window length.
        result_s      = acc_sum_s[ACC_W-1:AVG_LOG2];
    end

    // Framing state machine: cs_n, busy, bit/quiet counters and the shift register.
    always_ff @(posedge sck) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cs_n        <= 1'b1;
            busy_o      <= 1'b0;
            bit_cnt_r   <= '0;
            q_cnt_r     <= '0;
            sample_r    <= '0;
            frame_err_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (en_i) begin
                        state_r     <= ST_FRAME;
                        cs_n        <= 1'b0;
                        busy_o      <= 1'b1;
                        bit_cnt_r   <= '0;
                        sample_r    <= '0;
                        frame_err_r <= 1'b0;
                    end
                end
                ST_FRAME: begin
                    sample_r    <= sample_nxt_s;
                    frame_err_r <= frame_err_nxt_s;
                    if (bit_cnt_r == BIT_LAST) begin
                        state_r <= ST_QUIET;
                        cs_n    <= 1'b1;
                        q_cnt_r <= '0;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                    end
                end
                ST_QUIET: begin
                    // en_i is only honoured at the end of the conversion time.
                    if (q_cnt_r == Q_LAST) begin
                        if (en_i) begin
                            state_r     <= ST_FRAME;
                            cs_n        <= 1'b0;
                            bit_cnt_r   <= '0;
                            sample_r    <= '0;
                            frame_err_r <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_o  <= 1'b0;
                        end
                    end else begin
                        q_cnt_r <= q_cnt_r + Q_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cs_n    <= 1'b1;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Discard counter and averaging window (accumulator, count, window error).
    always_ff @(posedge sck) begin
        if (rst) begin
            discard_cnt_r <= '0;
            win_cnt_r     <= '0;
            acc_r         <= '0;
            win_err_r     <= 1'b0;
        end else if ((state_r == ST_IDLE) && en_i) begin
            // Every start re-arms the start-up discard and opens a fresh window.
            discard_cnt_r <= '0;
            win_cnt_r     <= '0;
            acc_r         <= '0;
            win_err_r     <= 1'b0;
        end else if (frame_done_s) begin
            if (!keep_s) begin
                discard_cnt_r <= discard_cnt_r + 4'd1;
            end else if (win_close_s) begin
                win_cnt_r <= '0;
                acc_r     <= '0;
                win_err_r <= 1'b0;
            end else begin
                win_cnt_r <= win_cnt_r + WIN_W'(1);
                acc_r     <= acc_sum_s;
                win_err_r <= win_err_nxt_s;
            end
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge sck) begin
        if (rst) begin
            data_o    <= '0;
            error_o   <= 1'b0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (win_close_s) begin
                if (!valid_o || ready_i) begin
                    data_o  <= result_s;
                    error_o <= win_err_nxt_s;
                    valid_o <= 1'b1;
                end else begin
                    // Held result wins; the new one is lost and flagged.
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_capture.sv
// Directed testbench for adc_serial_capture: default instance plus an
// averaging instance (AVG_LOG2=2, DISCARD=0), each fed by a small ADC model
// that plays a per-frame table of {lead bit, data, trail bit}.

module tb_adc_serial_capture;

    logic        sck;
    logic        rst_a, en_a, miso_a, ready_a;
    logic        cs_n_a, error_a, valid_a, overrun_a, busy_a;
    logic [11:0] data_a;
    logic        rst_b, en_b, miso_b, ready_b;
    logic        cs_n_b, error_b, valid_b, overrun_b, busy_b;
    logic [11:0] data_b;

    logic        lead_a [32];
    logic [11:0] dat_a  [32];
    logic        lead_b [32];
    logic [11:0] dat_b  [32];

    int n_checks;
    int n_pass;

    adc_serial_capture dut_a (
        .sck(sck), .rst(rst_a), .en_i(en_a), .miso(miso_a), .cs_n(cs_n_a),
        .data_o(data_a), .error_o(error_a), .valid_o(valid_a), .ready_i(ready_a),
        .overrun_o(overrun_a), .busy_o(busy_a)
    );

    adc_serial_capture #(.AVG_LOG2(2), .DISCARD(0)) dut_b (
        .sck(sck), .rst(rst_b), .en_i(en_b), .miso(miso_b), .cs_n(cs_n_b),
        .data_o(data_b), .error_o(error_b), .valid_o(valid_b), .ready_i(ready_b),
        .overrun_o(overrun_b), .busy_o(busy_b)
    );

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    // ADC model A: frame index restarts whenever the capture block is idle.
    initial begin
        int fa;
        int ia;
        logic [13:0] wa;
        fa = 0; ia = 0; wa = '0; miso_a = 1'b0;
        forever begin
            @(negedge sck);
            if (!busy_a) fa = 0;
            if (cs_n_a) begin
                ia = 0; miso_a = 1'b0;
            end else begin
                if (ia == 0) begin
                    wa = {lead_a[fa], dat_a[fa], 1'b0};
                    if (fa < 31) fa++;
                end
                miso_a = wa[13-ia];
                if (ia < 13) ia++;
            end
        end
    end

    // ADC model B.
    initial begin
        int fb;
        int ib;
        logic [13:0] wb;
        fb = 0; ib = 0; wb = '0; miso_b = 1'b0;
        forever begin
            @(negedge sck);
            if (!busy_b) fb = 0;
            if (cs_n_b) begin
                ib = 0; miso_b = 1'b0;
            end else begin
                if (ib == 0) begin
                    wb = {lead_b[fb], dat_b[fb], 1'b0};
                    if (fb < 31) fb++;
                end
                miso_b = wb[13-ib];
                if (ib < 13) ib++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid_a(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_a && n < 300);
    endtask

    task automatic wait_valid_b(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!valid_b && n < 300);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int vcount;
        n_checks = 0;
        n_pass   = 0;
        rst_a = 1'b1; en_a = 1'b0; ready_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b0; ready_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            lead_a[i] = 1'b0; dat_a[i] = 12'hA5C;
            lead_b[i] = 1'b0; dat_b[i] = 12'd0;
        end
        ticks(3);
        check("rst_cs_n",   32'(cs_n_a),    32'd1);
        check("rst_valid",  32'(valid_a),   32'd0);
        check("rst_busy",   32'(busy_a),    32'd0);
        check("rst_data",   32'(data_a),    32'd0);
        check("rst_err",    32'(error_a),   32'd0);
        check("rst_ovr",    32'(overrun_a), 32'd0);

        // Basic capture with start-up discard, periodic results, lead error.
        lead_a[4] = 1'b1; dat_a[4] = 12'h123;
        dat_a[5]  = 12'h7FF;
        rst_a = 1'b0; en_a = 1'b1;
        tick();
        check("e0_cs_low", 32'(cs_n_a), 32'd0);
        check("e0_busy",   32'(busy_a), 32'd1);
        wait_valid_a(n);
        check("first_valid_lat", 32'(n), 32'd68);
        check("first_data", 32'(data_a), 32'hA5C);
        check("first_err",  32'(error_a), 32'd0);
        check("first_cs_n", 32'(cs_n_a), 32'd1);
        tick();
        check("valid_one_cycle", 32'(valid_a), 32'd0);
        wait_valid_a(n);
        check("period_2", 32'(n), 32'd17);
        check("lead_err_data", 32'(data_a), 32'h123);
        check("lead_err_flag", 32'(error_a), 32'd1);
        wait_valid_a(n);
        check("period_3", 32'(n), 32'd18);
        check("after_err_data", 32'(data_a), 32'h7FF);
        check("after_err_flag", 32'(error_a), 32'd0);

        // Back-pressure: hold, overrun, simultaneous ready with new result.
        for (int i = 0; i < 32; i++) begin
            lead_a[i] = 1'b0; dat_a[i] = 12'h0F0;
        end
        dat_a[3] = 12'h111; dat_a[4] = 12'h222; dat_a[5] = 12'h333;
        rst_a = 1'b1; ready_a = 1'b0;
        ticks(2);
        rst_a = 1'b0;
        tick();
        ticks(68);
        check("bp_valid", 32'(valid_a), 32'd1);
        check("bp_data1", 32'(data_a), 32'h111);
        ticks(18);
        check("bp_overrun", 32'(overrun_a), 32'd1);
        check("bp_held", 32'(data_a), 32'h111);
        check("bp_valid_held", 32'(valid_a), 32'd1);
        tick();
        check("bp_overrun_1cyc", 32'(overrun_a), 32'd0);
        ticks(16);
        ready_a = 1'b1;
        tick();
        check("bp_load_data", 32'(data_a), 32'h333);
        check("bp_load_valid", 32'(valid_a), 32'd1);
        check("bp_load_noovr", 32'(overrun_a), 32'd0);
        tick();
        check("bp_drain", 32'(valid_a), 32'd0);

        // en_i dropped mid-frame: frame and quiet finish, then idle; restart re-discards.
        for (int i = 0; i < 32; i++) begin
            lead_a[i] = 1'b0; dat_a[i] = 12'h5A5;
        end
        rst_a = 1'b1;
        ticks(2);
        rst_a = 1'b0;
        tick();
        ticks(5);
        en_a = 1'b0;
        ticks(5);
        check("endrop_frame_kept", 32'(cs_n_a), 32'd0);
        ticks(7);
        check("endrop_quiet_busy", 32'(busy_a), 32'd1);
        tick();
        check("endrop_idle_busy", 32'(busy_a), 32'd0);
        check("endrop_idle_cs", 32'(cs_n_a), 32'd1);
        ticks(3);
        check("endrop_stay_idle", 32'(busy_a), 32'd0);
        en_a = 1'b1;
        tick();
        wait_valid_a(n);
        check("reen_discard_lat", 32'(n), 32'd68);
        check("reen_data", 32'(data_a), 32'h5A5);

        // Reset at frame bit 7 of the next frame while a result is held.
        ready_a = 1'b0;
        ticks(11);
        rst_a = 1'b1;
        tick();
        check("midrst_cs_n", 32'(cs_n_a), 32'd1);
        check("midrst_valid", 32'(valid_a), 32'd0);
        check("midrst_busy", 32'(busy_a), 32'd0);
        check("midrst_data", 32'(data_a), 32'd0);
        tick();
        rst_a = 1'b0; en_a = 1'b0; ready_a = 1'b1;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_a) vcount++;
        end
        check("midrst_no_partial", 32'(vcount), 32'd0);
        check("midrst_idle_cs", 32'(cs_n_a), 32'd1);

        // Averaging instance: 100,101,102(lead err),104 -> 101 err; then 8,8,8,9 -> 8.
        dat_b[0] = 12'd100; dat_b[1] = 12'd101; dat_b[2] = 12'd102; dat_b[3] = 12'd104;
        lead_b[2] = 1'b1;
        dat_b[4] = 12'd8; dat_b[5] = 12'd8; dat_b[6] = 12'd8; dat_b[7] = 12'd9;
        rst_b = 1'b0; en_b = 1'b1;
        tick();
        wait_valid_b(n);
        check("avg_lat", 32'(n), 32'd68);
        check("avg_data", 32'(data_b), 32'd101);
        check("avg_err", 32'(error_b), 32'd1);
        tick();
        check("avg_one_cycle", 32'(valid_b), 32'd0);
        wait_valid_b(n);
        check("avg2_lat", 32'(n), 32'd71);
        check("avg2_data", 32'(data_b), 32'd8);
        check("avg2_err", 32'(error_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_serial_capture.md
# adc_serial_capture

Parametrised serial-ADC capture block, successor to the fixed LTC2315 frame reader. Generates the chip-select framing from the continuously running ADC serial clock, shifts in one conversion per frame with configurable leading/data/trailing bit counts, discards start-up samples, and optionally box-car averages 2^AVG_LOG2 samples. Results go out on a valid/ready handshake with overrun reporting to the downstream receive pipeline.

## Interface
- DATA_W, 12: conversion data bits per frame, MSB first; also the output width.
- LEAD_BITS, 1: bits before data that must read 0 (start bits); ≥1.
- TRAIL_BITS, 1: bits after data, sampled and ignored; ≥0.
- QUIET_CYCLES, 4: cycles cs_n is held high between frames (conversion time); ≥1.
- DISCARD, 3: frames dropped after each start (reset or leaving IDLE); 0..15.
- AVG_LOG2, 0: log2 of samples averaged per result; 0..4.
- sck  input  1  clock; every register updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en_i  input  1  run enable; sampled each edge.
- miso  input  1  ADC serial data.
- cs_n  output  1  ADC chip select, registered, active-low.
- data_o  output  DATA_W  result (average when AVG_LOG2>0).
- error_o  output  1  any lead bit in the result's window was 1; qualified by valid_o.
- valid_o  output  1  data_o/error_o valid.
- ready_i  input  1  downstream accept.
- overrun_o  output  1  one-cycle pulse: a result was dropped.
- busy_o  output  1  state ≠ IDLE.

## Operation
- FRAME_BITS = LEAD_BITS+DATA_W+TRAIL_BITS; frame period = FRAME_BITS+QUIET_CYCLES (default 18).
- States: IDLE (cs_n=1), FRAME (cs_n=0, bit_cnt 0..FRAME_BITS-1), QUIET (cs_n=1, q_cnt 0..QUIET_CYCLES-1).
- IDLE → FRAME on an edge with en_i=1; bit_cnt=0; discard and window counters cleared.
- FRAME: edge with bit_cnt=k samples miso as bit k. k<LEAD_BITS: lead check, miso=1 sets window error. Next DATA_W bits shift into sample register MSB first. Remaining bits ignored. Edge with k=FRAME_BITS-1 → QUIET.
- QUIET: after QUIET_CYCLES edges → FRAME if en_i=1, else IDLE. en_i low never aborts a frame or quiet period.
- Frame completion (edge leaving FRAME): if discard_cnt<DISCARD, increment and drop. Otherwise add sample to accumulator (DATA_W+AVG_LOG2 bits, unsigned, no overflow) and increment win_cnt. When win_cnt reaches 2^AVG_LOG2, result = accumulator bits [DATA_W+AVG_LOG2-1 : AVG_LOG2] (truncating), error = OR of lead errors in the window; accumulator, error and win_cnt cleared.
- Output register: on a result edge, load if valid_o=0 or ready_i=1; else keep held result, pulse overrun_o, drop new result.
- valid_o clears on an edge with valid_o&&ready_i and no new result; a simultaneous new result loads, valid_o stays 1.
- Reset: all outputs to reset values on the next edge, any frame aborted; cs_n=1 the same cycle. Counters cleared; discard restarts.
- Reset values: cs_n=1, data_o=0, error_o=0, valid_o=0, overrun_o=0, busy_o=0.

## Timing
- Edge e0 samples en_i=1 in IDLE: cs_n low after e0; bit k sampled at e0+1+k.
- Frame n spans e0+(n-1)·period … e0+(n-1)·period+FRAME_BITS; cs_n rises at the last edge.
- Result valid_o rises on the same edge cs_n rises at the window-closing frame. Defaults: first valid_o after e0+68 (frame 4).
- Result from last data bit to valid_o: TRAIL_BITS+1 edges.
- overrun_o is high exactly one cycle, on the dropped-result edge.
- Back-to-back frames have no gap beyond QUIET_CYCLES while en_i=1.

## Test plan
- Defaults, ready_i=1, ADC model sends 0,0xA5C,0 every frame: frames 1–3 give no valid. valid_o after e0+68 with data_o=0xA5C, error_o=0. Then valid_o every 18 cycles, one cycle wide.
- Defaults, frame 5 lead bit=1: that result has error_o=1 and data intact; frame 6 error_o=0.
- AVG_LOG2=2, DISCARD=0, samples 100,101,102,104: one valid with data_o=101 (407>>2). Lead error in sample 3 only gives error_o=1.
- Defaults, ready_i=0 from start: first result held (valid_o=1). Next result gives overrun_o pulse and data_o unchanged. Raising ready_i together with a result edge loads the new value, valid_o stays 1, no overrun.
- en_i dropped at frame bit 5: frame and quiet complete, then IDLE (cs_n=1, busy_o=0). Re-enable discards 3 frames again.
- rst asserted at frame bit 7: next edge cs_n=1, valid_o=0, state IDLE. Partial sample never output.
